// File: rtl/mem_port_master.sv
// mem_port_master: single-issue host-to-RAM initiator that sequences cs/we/oe and owns the shared data bus
module mem_port_master #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);
  localparam int CW = $clog2(READ_LATENCY + 1);
  typedef enum logic [2:0] {IDLE, WRITE, READ, RESP, TURN} state_t;
  state_t state, next_state;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-1:0] dout;
  logic drive, accept, read_done;
  logic nxt_cs, nxt_we, nxt_oe, nxt_drive;
  assign req_ready = state == IDLE && !rst;
  assign busy = state != IDLE;
  assign accept = req_valid && req_ready;
  assign read_done = state == READ && cnt == '0;
  assign mem_data = drive ? dout : 'z;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      dout <= '0;
      drive <= 1'b0;
      mem_addr <= '0;
      mem_cs <= 1'b0;
      mem_we <= 1'b0;
      mem_oe <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state <= next_state;
      cnt <= state == READ ? cnt - CW'(1) : CW'(READ_LATENCY);
      drive <= nxt_drive;
      mem_cs <= nxt_cs;
      mem_we <= nxt_we;
      mem_oe <= nxt_oe;
      rsp_valid <= next_state == RESP;
      if (accept) begin
        mem_addr <= req_addr;
        dout <= req_wdata;
      end
      if (read_done) rsp_rdata <= mem_data;
    end
  end
  always_comb begin
    next_state = state == IDLE ? (accept ? (req_we ? WRITE : READ) : IDLE) :
                 state == READ ? (read_done ? RESP : READ) :
                 state == RESP ? (rsp_ready ? TURN : RESP) : IDLE;
  end
  always_comb begin
    nxt_cs = next_state == WRITE || next_state == READ;
    nxt_we = next_state == WRITE;
    nxt_oe = next_state == READ;
    nxt_drive = next_state == WRITE;
  end
endmodule
